// File: rtl/seg_display_scanner.sv
// seg_display_scanner
//   Feeds a 4-to-7 segment decoder. A processor value is captured into a
//   shadow register on load and committed to the display register only at a
//   frame boundary, so a frame never shows a mix of old and new nibbles.
//   The committed value is scanned one nibble per digit slot. The first cycle
//   of every slot is a ghosting guard with all digits off.
//
// Optional build macro: BLANK_LEADING_ZERO_EN
//   When defined, digit i > 0 is held off while nibbles i..NUM_DIGITS-1 of
//   the displayed value are all zero. Digit 0 is always shown.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   data_in    in   [DATA_W]     value to display
//   load       in   capture strobe for data_in
//   nibble_out out  [4]          nibble of the scanned digit (decoder input)
//   digit_en   out  [NUM_DIGITS] active-low digit enables
//   busy       out  captured value waiting for the next frame boundary
//   frame_done out  one-cycle pulse in the first cycle of each frame
module seg_display_scanner #(
    parameter int DATA_W      = 8,
    parameter int REFRESH_DIV = 50000,
    localparam int NUM_DIGITS = DATA_W / 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  load,
    output logic [3:0]            nibble_out,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]            div_cnt;
    logic [IDX_W-1:0]            idx;
    logic [NUM_DIGITS-1:0][3:0]  shadow;
    logic [NUM_DIGITS-1:0][3:0]  disp;
    logic                        pending;

    logic slot_end;
    logic bnd;   // last cycle of the last slot: frame boundary

    assign slot_end = (div_cnt == CNT_LAST);
    assign bnd      = slot_end && (idx == IDX_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt    <= '0;
            idx        <= '0;
            shadow     <= '0;
            disp       <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (slot_end) begin
                div_cnt <= '0;
                idx     <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end else begin
                div_cnt <= div_cnt + CNT_W'(1);
            end

            frame_done <= bnd;

            if (load)
                shadow <= data_in;

            if (bnd) begin
                // A load on the boundary bypasses the shadow so it is not
                // delayed by a whole frame.
                if (load)
                    disp <= data_in;
                else if (pending)
                    disp <= shadow;
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    assign nibble_out = disp[idx];
    assign busy       = pending;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        logic sel;
        logic show;

        // div_cnt == 0 is the guard cycle: nothing lit.
        assign sel = (idx == IDX_W'(i)) && (div_cnt != '0);

`ifdef BLANK_LEADING_ZERO_EN
        if (i == 0) begin : g_first
            assign show = 1'b1;
        end else begin : g_upper
            assign show = |disp[NUM_DIGITS-1:i];
        end
`else
        assign show = 1'b1;
`endif

        assign digit_en[i] = ~(sel && show);
    end

endmodule
